ser_frame_loader: RTL and testbench

SER_FRAME_LOADER -- requirements
Module: ser_frame_loader

---
 rtl/ser_frame_loader_pkg.sv | 28 ++
 rtl/ser_frame_loader_shift_in_reg.sv | 36 +++
 rtl/ser_frame_loader.sv | 129 ++++++++++++
 tb/tb_ser_frame_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ser_frame_loader_pkg.sv
// Shared definitions for the serial frame loader.
//   state_e   : frame FSM state encoding
//   START_BIT : line level that opens a frame
//   STOP_BIT  : line level that must close a frame
//   clog2     : ceil(log2(value)), minimum 1, for counter/index widths
package ser_frame_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Never returns 0 so a counter built from it always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/ser_frame_loader_shift_in_reg.sv
// WIDTH-bit assembly register written one bit at a time at a given index.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (clears the register)
//   clr_i  : synchronous clear, has priority over en_i
//   en_i   : write bit_i into position idx_i
//   idx_i  : bit position to write
//   bit_i  : bit value to write
//   q_o    : current register contents
module shift_in_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q[idx_i] <= bit_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ser_frame_loader.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit. A good frame is presented on data_out with a one-cycle
// load pulse for a downstream register; bad frames pulse an error instead.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   ser_valid  : qualifies ser_in; bits are consumed only when high
//   ser_in     : serial data bit
//   load       : one-cycle pulse, data_out holds a newly accepted word
//   data_out   : last accepted word
//   busy       : a frame is in progress
//   frame_err  : one-cycle pulse, stop bit was 0
//   parity_err : one-cycle pulse, parity mismatch with a good stop bit
module ser_frame_loader
    import ser_frame_loader_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_in,
    output logic             load,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err
);

    localparam int unsigned      CNT_W      = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WIDTH - 1);
    localparam bit               HAS_PARITY = (PARITY_EN != 0);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             parity_ok_q;
    logic             load_q;
    logic             busy_q;
    logic             frame_err_q;
    logic             parity_err_q;
    logic [WIDTH-1:0] data_q;

    logic [WIDTH-1:0] asm_word;
    logic             asm_clr;
    logic             asm_en;

    // Assembly register is cleared on the start bit and written while in DATA.
    assign asm_clr = ser_valid && (state_q == ST_IDLE) && (ser_in == START_BIT);
    assign asm_en  = ser_valid && (state_q == ST_DATA);

    shift_in_reg #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_asm (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (asm_clr),
        .en_i  (asm_en),
        .idx_i (cnt_q),
        .bit_i (ser_in),
        .q_o   (asm_word)
    );

    // Frame FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            parity_ok_q  <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            data_q       <= '0;
        end else begin
            load_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (ser_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        // A 1 here is idle line and is simply dropped.
                        if (ser_in == START_BIT) begin
                            state_q <= ST_DATA;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        // Counter parks at LAST_IDX rather than wrapping.
                        if (cnt_q == LAST_IDX) begin
                            state_q <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        // Even parity: data bits plus parity bit XOR to zero.
                        parity_ok_q <= ~(^{asm_word, ser_in});
                        state_q     <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (ser_in != STOP_BIT) begin
                            frame_err_q <= 1'b1;
                        end else if (HAS_PARITY && !parity_ok_q) begin
                            parity_err_q <= 1'b1;
                        end else begin
                            load_q <= 1'b1;
                            data_q <= asm_word;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign load       = load_q;
    assign data_out   = data_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_ser_frame_loader.sv
// Bench for ser_frame_loader driving a downstream register (reg_val).
// The reference model collects consumed bits into a queue and judges each
// complete frame from its bit list.
module tb_ser_frame_loader;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned FRAME_LEN = WIDTH + 3;

    logic             clk;
    logic             rst;
    logic             ser_valid;
    logic             ser_in;
    logic             load;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             frame_err;
    logic             parity_err;
    logic [WIDTH-1:0] reg_val;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state
    logic             q_bits[$];
    logic             exp_load;
    logic             exp_ferr;
    logic             exp_perr;
    logic [WIDTH-1:0] exp_data;
    logic [WIDTH-1:0] exp_reg;

    ser_frame_loader #(
        .WIDTH     (WIDTH),
        .PARITY_EN (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_valid  (ser_valid),
        .ser_in     (ser_in),
        .load       (load),
        .data_out   (data_out),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    // Downstream register fed by load / data_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) reg_val <= '0;
        else if (load) reg_val <= data_out;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_busy;
        exp_busy = (q_bits.size() != 0);
        check_eq({tag, "/busy,load,ferr,perr,data"},
                 32'({busy, load, frame_err, parity_err, data_out}),
                 32'({exp_busy, exp_load, exp_ferr, exp_perr, exp_data}));
        check_eq({tag, "/reg_val"}, 32'(reg_val), 32'(exp_reg));
    endtask

    // Frame-level judgement of one consumed bit
    task automatic model_bit(input logic b);
        logic [WIDTH-1:0] d;
        if (q_bits.size() == 0 && b == 1'b1) return;
        q_bits.push_back(b);
        if (q_bits.size() == FRAME_LEN) begin
            for (int i = 0; i < int'(WIDTH); i++) d[i] = q_bits[i + 1];
            if (q_bits[FRAME_LEN - 1] == 1'b0) begin
                exp_ferr = 1'b1;
            end else if ((^d) != q_bits[WIDTH + 1]) begin
                exp_perr = 1'b1;
            end else begin
                exp_load = 1'b1;
                exp_data = d;
            end
            q_bits.delete();
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        exp_load = 1'b0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        exp_data = '0;
        exp_reg  = '0;
    endtask

    // One clock: apply inputs, advance the model, check just after the edge
    task automatic step(input logic v, input logic b, input string tag);
        ser_valid = v;
        ser_in    = b;
        @(posedge clk);
        if (exp_load) exp_reg = exp_data;
        exp_load = 1'b0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        if (v && !rst) model_bit(b);
        #1;
        check_outputs(tag);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d, input int unsigned gap,
                              input logic flip_par, input logic bad_stop, input string tag);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < int'(WIDTH); i++) bits.push_back(d[i]);
        bits.push_back((^d) ^ flip_par);
        bits.push_back(~bad_stop);
        foreach (bits[i]) begin
            repeat (gap) step(1'b0, 1'($urandom_range(0, 1)), tag);
            step(1'b1, bits[i], tag);
        end
    endtask

    // Asynchronous reset away from the clock edge, outputs checked at once
    task automatic reset_mid(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, "/async"});
        step(1'b0, 1'b0, tag);
        step(1'b1, 1'b0, tag);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        int unsigned      nbits;

        rst       = 1'b1;
        ser_valid = 1'b0;
        ser_in    = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        #2 rst = 1'b0;

        step(1'b1, 1'b1, "idle");
        step(1'b1, 1'b1, "idle");

        send_frame(8'hA5, 0, 1'b0, 1'b0, "a5");
        check_eq("a5_load_data", 32'(data_out), 32'h0000_00A5);
        step(1'b1, 1'b1, "a5_tail");
        check_eq("a5_reg_val", 32'(reg_val), 32'h0000_00A5);

        send_frame(8'h5A, 0, 1'b1, 1'b0, "5a_par");
        check_eq("5a_perr", 32'(parity_err), 32'h1);
        step(1'b1, 1'b1, "5a_tail");
        check_eq("5a_keep", 32'(data_out), 32'h0000_00A5);

        send_frame(8'h3C, 3, 1'b0, 1'b0, "3c_gap");
        step(1'b0, 1'b1, "3c_tail");
        check_eq("3c_reg_val", 32'(reg_val), 32'h0000_003C);

        send_frame(8'hFF, 0, 1'b0, 1'b1, "ff_stop");
        check_eq("ff_ferr", 32'(frame_err), 32'h1);
        step(1'b1, 1'b1, "ff_tail");

        send_frame(8'h01, 0, 1'b0, 1'b0, "b2b_01");
        send_frame(8'h80, 0, 1'b0, 1'b0, "b2b_80");
        check_eq("b2b_data", 32'(data_out), 32'h0000_0080);
        step(1'b1, 1'b1, "b2b_tail");

        step(1'b1, 1'b0, "77_start");
        d = 8'h77;
        for (int i = 0; i < 4; i++) step(1'b1, d[i], "77_bits");
        reset_mid("77_rst");
        step(1'b1, 1'b1, "77_idle");
        send_frame(8'h12, 0, 1'b0, 1'b0, "12");
        step(1'b1, 1'b1, "12_tail");
        check_eq("12_reg_val", 32'(reg_val), 32'h0000_0012);

        // Randomised frames, errors, gaps, idle bits and mid-frame resets
        for (int n = 0; n < 200; n++) begin
            d = WIDTH'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                nbits = $urandom_range(1, FRAME_LEN - 1);
                step(1'b1, 1'b0, "rnd_part");
                for (int i = 1; i < int'(nbits); i++)
                    step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rnd_part");
                reset_mid("rnd_rst");
            end else begin
                send_frame(d, $urandom_range(0, 2),
                           1'($urandom_range(0, 5) == 0),
                           1'($urandom_range(0, 5) == 0), "rnd");
            end
            repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b1, "rnd_idle");
        end
        step(1'b0, 1'b1, "final");
        step(1'b0, 1'b1, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
